// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, LSD first, carry registered
// between digits; operands and result move over valid/ready handshakes.
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             entAcarreo,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] suma,
   output logic             salAcarreo,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] suma_q, suma_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT:0]   dsum_s;
   logic [31:0]      off_s;
   logic             msb_cin_s;

   // One digit of ripple addition on the low bits of the shifting operand registers
   always_comb begin
      dsum_s    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
      off_s     = 32'(cnt_q) * DIGIT;
      // carry into the MSB recovered from the MSB sum bit and its operand bits
      msb_cin_s = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum_s[DIGIT-1];
   end

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      suma_d  = suma_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = entAcarreo ^ sub;
               cnt_d   = '0;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            suma_d  = (suma_q & ~(DMASK << off_s)) | (WIDTH'(dsum_s[DIGIT-1:0]) << off_s);
            carry_d = dsum_s[DIGIT];
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            if (cnt_q == CW'(N - 1)) begin
               cout_d  = dsum_s[DIGIT];
               ovf_d   = msb_cin_s ^ dsum_s[DIGIT];
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         suma_q  <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         suma_q  <= suma_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign suma       = suma_q;
   assign salAcarreo = cout_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: four configurations, queue scoreboard,
// directed arithmetic/boundary scenarios and random back-to-back traffic.
module tb_digit_serial_adder;

   localparam int NC = 4;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid_s [NC];
   logic        out_ready_s[NC];
   logic        cin_s      [NC];
   logic        sub_s      [NC];
   logic [31:0] a_s        [NC];
   logic [31:0] b_s        [NC];
   logic        in_ready_w [NC];
   logic        out_valid_w[NC];
   logic        cout_w     [NC];
   logic        ovf_w      [NC];
   wire  [15:0] suma0;
   wire  [7:0]  suma1;
   wire  [31:0] suma2;
   wire  [15:0] suma3;
   logic [31:0] res        [NC];

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   always_comb begin
      res[0] = {16'd0, suma0};
      res[1] = {24'd0, suma1};
      res[2] = suma2;
      res[3] = {16'd0, suma3};
   end

   digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]),
      .a(a_s[0][15:0]), .b(b_s[0][15:0]), .entAcarreo(cin_s[0]), .sub(sub_s[0]),
      .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]), .suma(suma0),
      .salAcarreo(cout_w[0]), .overflow(ovf_w[0]));
   digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]),
      .a(a_s[1][7:0]), .b(b_s[1][7:0]), .entAcarreo(cin_s[1]), .sub(sub_s[1]),
      .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]), .suma(suma1),
      .salAcarreo(cout_w[1]), .overflow(ovf_w[1]));
   digit_serial_adder #(.WIDTH(32), .DIGIT(8)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_w[2]),
      .a(a_s[2]), .b(b_s[2]), .entAcarreo(cin_s[2]), .sub(sub_s[2]),
      .out_valid(out_valid_w[2]), .out_ready(out_ready_s[2]), .suma(suma2),
      .salAcarreo(cout_w[2]), .overflow(ovf_w[2]));
   digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[3]), .in_ready(in_ready_w[3]),
      .a(a_s[3][15:0]), .b(b_s[3][15:0]), .entAcarreo(cin_s[3]), .sub(sub_s[3]),
      .out_valid(out_valid_w[3]), .out_ready(out_ready_s[3]), .suma(suma3),
      .salAcarreo(cout_w[3]), .overflow(ovf_w[3]));

   function automatic int wd(int k);
      case (k)
         0: return 16;
         1: return 8;
         2: return 32;
         default: return 16;
      endcase
   endfunction

   function automatic int dg(int k);
      case (k)
         0: return 4;
         1: return 1;
         2: return 8;
         default: return 16;
      endcase
   endfunction

   function automatic logic [31:0] msk(int w);
      if (w == 32) return 32'hFFFF_FFFF;
      return (32'd1 << w) - 32'd1;
   endfunction

   // Reference: full-width add of a and (possibly inverted) b, signed overflow from signs
   function automatic exp_t model(int k, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
      int          w;
      logic [31:0] aa, bb;
      logic [32:0] full;
      exp_t        e;
      w      = wd(k);
      aa     = a & msk(w);
      bb     = sub ? (~b & msk(w)) : (b & msk(w));
      full   = {1'b0, aa} + {1'b0, bb} + {32'd0, cin ^ sub};
      e.sum  = full[31:0] & msk(w);
      e.cout = full[w];
      e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
      return e;
   endfunction

   function automatic logic [31:0] pick(int w);
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = 32'd0;
         1: v = msk(w);
         2: v = 32'd1 << (w - 1);
         default: v = $urandom;
      endcase
      return v & msk(w);
   endfunction

   // One full operation: accept, latency, result, handshake
   task automatic run_op(int k, logic [31:0] a, logic [31:0] b, logic cin, logic sub,
                         logic [31:0] es, logic ec, logic eo, string nm);
      exp_t e;
      int   lat;
      @(negedge clk);
      checks++;
      if (in_ready_w[k] !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready got %b want 1", nm, in_ready_w[k]);
      end
      a_s[k] = a; b_s[k] = b; cin_s[k] = cin; sub_s[k] = sub; in_valid_s[k] = 1'b1;
      e.sum = es; e.cout = ec; e.ovf = eo;
      exp_q.push_back(e);
      @(negedge clk);
      in_valid_s[k] = 1'b0;
      lat = 0;
      while (out_valid_w[k] !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != wd(k) / dg(k)) begin
         errors++;
         $display("FAIL %s latency got %0d want %0d", nm, lat, wd(k) / dg(k));
      end
      e = exp_q.pop_front();
      checks++;
      if (res[k] !== e.sum || cout_w[k] !== e.cout || ovf_w[k] !== e.ovf) begin
         errors++;
         $display("FAIL %s result got %h/%b/%b want %h/%b/%b", nm, res[k], cout_w[k],
                  ovf_w[k], e.sum, e.cout, e.ovf);
      end
      out_ready_s[k] = 1'b1;
      @(negedge clk);
      out_ready_s[k] = 1'b0;
      checks++;
      if (out_valid_w[k] !== 1'b0 || in_ready_w[k] !== 1'b1 || res[k] !== e.sum) begin
         errors++;
         $display("FAIL %s post_handshake got ov=%b ir=%b s=%h want 0/1/%h", nm,
                  out_valid_w[k], in_ready_w[k], res[k], e.sum);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if (in_ready_w[k] !== 1'b1 || out_valid_w[k] !== 1'b0 || res[k] !== 32'd0 ||
             cout_w[k] !== 1'b0 || ovf_w[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset[%0d] got ir=%b ov=%b s=%h c=%b o=%b want 1/0/0/0/0", k,
                     in_ready_w[k], out_valid_w[k], res[k], cout_w[k], ovf_w[k]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      run_op(0, 32'h1234, 32'h4321, 1'b0, 1'b0, 32'h5555, 1'b0, 1'b0, "add_basic");
      run_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, "add_wrap");
      run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, "add_ovf");
      run_op(0, 32'h00FF, 32'h0001, 1'b1, 1'b0, 32'h0101, 1'b0, 1'b0, "add_cin");
   endtask

   task automatic test_sub();
      run_op(0, 32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0, "sub_borrow");
      run_op(0, 32'h0007, 32'h0005, 1'b0, 1'b1, 32'h0002, 1'b1, 1'b0, "sub_noborrow");
      run_op(0, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, "sub_ovf");
      run_op(0, 32'h0010, 32'h0001, 1'b1, 1'b1, 32'h000E, 1'b1, 1'b0, "sub_bin");
   endtask

   task automatic test_backpressure();
      exp_t        e;
      int          g;
      logic [31:0] hold;
      @(negedge clk);
      a_s[0] = 32'h1111; b_s[0] = 32'h2222; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
      in_valid_s[0] = 1'b1;
      e.sum = 32'h3333; e.cout = 1'b0; e.ovf = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      g = 0;
      // keep in_valid high and scramble operands while busy: all must be ignored
      while (out_valid_w[0] !== 1'b1 && g < 200) begin
         a_s[0] = $urandom; b_s[0] = $urandom; cin_s[0] = 1'($urandom); sub_s[0] = 1'($urandom);
         @(negedge clk);
         g++;
      end
      hold = res[0];
      for (int i = 0; i < 10; i++) begin
         a_s[0] = $urandom; b_s[0] = $urandom;
         @(negedge clk);
         checks++;
         if (out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0 || res[0] !== hold) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got ov=%b ir=%b s=%h want 1/0/%h", i,
                     out_valid_w[0], in_ready_w[0], res[0], hold);
         end
      end
      e = exp_q.pop_front();
      checks++;
      if (res[0] !== e.sum || cout_w[0] !== e.cout || ovf_w[0] !== e.ovf) begin
         errors++;
         $display("FAIL bp_result got %h/%b/%b want %h/%b/%b", res[0], cout_w[0], ovf_w[0],
                  e.sum, e.cout, e.ovf);
      end
      in_valid_s[0] = 1'b0;
      out_ready_s[0] = 1'b1;
      @(negedge clk);
      out_ready_s[0] = 1'b0;
      checks++;
      if (in_ready_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0 || res[0] !== 32'h3333) begin
         errors++;
         $display("FAIL bp_release got ir=%b ov=%b s=%h want 1/0/3333", in_ready_w[0],
                  out_valid_w[0], res[0]);
      end
   endtask

   task automatic test_reset_mid_calc();
      @(negedge clk);
      a_s[0] = 32'hAAAA; b_s[0] = 32'h1111; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
      in_valid_s[0] = 1'b1;
      @(negedge clk);
      in_valid_s[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0 || res[0] !== 32'd0 ||
          cout_w[0] !== 1'b0 || ovf_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL midreset got ir=%b ov=%b s=%h c=%b o=%b want 1/0/0/0/0",
                  in_ready_w[0], out_valid_w[0], res[0], cout_w[0], ovf_w[0]);
      end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL midreset_idle got ov=%b ir=%b want 0/1", out_valid_w[0], in_ready_w[0]);
      end
      run_op(0, 32'h0F0F, 32'h0101, 1'b0, 1'b0, 32'h1010, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_configs();
      run_op(1, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, "w8d1_ovf");
      run_op(1, 32'h03, 32'h05, 1'b0, 1'b1, 32'hFE, 1'b0, 1'b0, "w8d1_sub");
      run_op(2, 32'h89AB_CDEF, 32'h1234_5678, 1'b0, 1'b1, 32'h7777_7777, 1'b1, 1'b1, "w32d8_sub");
      run_op(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "w32d8_cin");
      run_op(3, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, "w16d16_wrap");
      run_op(3, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, "w16d16_sub");
   endtask

   task automatic test_back_to_back(int k, int nops);
      int rcvd;
      rcvd = 0;
      exp_q.delete();
      fork
         begin
            for (int i = 0; i < nops; i++) begin
               int g;
               @(negedge clk);
               a_s[k] = pick(wd(k)); b_s[k] = pick(wd(k));
               cin_s[k] = 1'($urandom); sub_s[k] = 1'($urandom);
               in_valid_s[k] = 1'b1;
               g = 0;
               while (in_ready_w[k] !== 1'b1 && g < 100) begin
                  @(negedge clk);
                  g++;
               end
               if (g >= 100) begin
                  checks++;
                  errors++;
                  $display("FAIL b2b[%0d] accept timeout at op %0d", k, i);
                  break;
               end
               exp_q.push_back(model(k, a_s[k], b_s[k], cin_s[k], sub_s[k]));
            end
            @(negedge clk);
            in_valid_s[k] = 1'b0;
         end
         begin
            int guard;
            exp_t e;
            guard = 0;
            while (rcvd < nops && guard < nops * 40) begin
               @(negedge clk);
               guard++;
               out_ready_s[k] = ($urandom_range(0, 3) != 0);
               if (out_valid_w[k] === 1'b1 && out_ready_s[k]) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL b2b[%0d] unexpected result %h", k, res[k]);
                  end else begin
                     e = exp_q.pop_front();
                     if (res[k] !== e.sum || cout_w[k] !== e.cout || ovf_w[k] !== e.ovf) begin
                        errors++;
                        $display("FAIL b2b[%0d] op %0d got %h/%b/%b want %h/%b/%b", k, rcvd,
                                 res[k], cout_w[k], ovf_w[k], e.sum, e.cout, e.ovf);
                     end
                  end
                  rcvd++;
               end
            end
            out_ready_s[k] = 1'b0;
            checks++;
            if (rcvd != nops) begin
               errors++;
               $display("FAIL b2b[%0d] count got %0d want %0d", k, rcvd, nops);
            end
         end
      join
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < NC; k++) begin
         in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0; cin_s[k] = 1'b0; sub_s[k] = 1'b0;
         a_s[k] = 32'd0; b_s[k] = 32'd0;
      end
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_reset_mid_calc();
      test_configs();
      for (int k = 0; k < NC; k++) begin
         test_back_to_back(k, 1000);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
